// File: rtl/tc4_gf2_mul_sched.sv
// tc4_gf2_mul_sched
// Sequencer/scheduler for a four-way Toom-Cook style carry-less (GF(2)[x])
// multiplier. Each WIDTH-bit operand is split into four LIMB-bit limbs. One
// shared bit-serial limb multiplier is time-multiplexed over all 16 limb
// cross-products. Each partial product is XOR-accumulated into a
// 2*WIDTH-bit result at offset (i+j)*LIMB.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   clr       synchronous abort back to IDLE (clears the accumulator)
//   in_valid  operands a/b valid;   in_ready  block accepts operands (IDLE)
//   a, b      WIDTH-bit multiplicand / multiplier
//   out_valid c holds a finished product; out_ready consumer accepts c
//   c         2*WIDTH-bit carry-less product, driven from the accumulator
//   busy      high while multiplying or accumulating
//
// Optional feature: define TC4_SKIP_ZERO_LIMB_EN to skip the bit-serial
// phase of any cross-product whose a or b limb is zero. Each such product
// then costs a single accumulate cycle.

module tc4_gf2_mul_sched #(
  parameter int WIDTH = 163,
  parameter int LIMB  = 41
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
);

  localparam int EXT = 4 * LIMB;
  localparam int PW  = 2 * LIMB - 1;
  localparam int CW  = 2 * WIDTH;
  localparam int BW  = $clog2(LIMB + 1);
  localparam int SW  = $clog2(6 * LIMB + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(LIMB - 1);

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic [CW-1:0]     acc;
  logic [PW-1:0]     prod;
  logic [3:0]        p;
  logic [BW-1:0]     bit_cnt;

  logic [EXT-1:0]    a_ext, b_ext;
  logic [LIMB-1:0]   a_limbs [4];
  logic [LIMB-1:0]   b_limbs [4];
  logic [LIMB-1:0]   a_limb, b_limb;
  logic [1:0]        i_idx, j_idx;
  logic [2:0]        ij;
  logic [SW-1:0]     shift_amt;
  logic [PW-1:0]     b_shift;
  logic [CW-1:0]     prod_placed;

  // Zero-extend the operands so the top limb reads zeros above WIDTH-1.
  assign a_ext = EXT'(a_reg);
  assign b_ext = EXT'(b_reg);

  for (genvar k = 0; k < 4; k++) begin : g_limb
    assign a_limbs[k] = a_ext[k*LIMB +: LIMB];
    assign b_limbs[k] = b_ext[k*LIMB +: LIMB];
  end

  assign i_idx  = p[3:2];
  assign j_idx  = p[1:0];
  assign a_limb = a_limbs[i_idx];
  assign b_limb = b_limbs[j_idx];
  assign ij     = {1'b0, i_idx} + {1'b0, j_idx};

  assign b_shift   = PW'(b_limb) << bit_cnt;
  assign shift_amt = SW'(int'(ij) * LIMB);
  // Bits shifted past 2*WIDTH-1 are always zero, so truncation is lossless.
  assign prod_placed = CW'(prod) << shift_amt;

`ifdef TC4_SKIP_ZERO_LIMB_EN
  logic       skip_first, skip_next;
  logic [3:0] p_next;

  // The first product uses the incoming operands, later ones the registers.
  assign skip_first = (a[LIMB-1:0] == '0) || (b[LIMB-1:0] == '0);
  assign p_next     = p + 4'd1;
  assign skip_next  = (a_limbs[p_next[3:2]] == '0) || (b_limbs[p_next[1:0]] == '0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // clr overrides every other transition.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = MUL;
`ifdef TC4_SKIP_ZERO_LIMB_EN
          if (skip_first) state_nx = ACC;
`endif
        end
      end
      MUL: begin
        if (bit_cnt == LAST_BIT) state_nx = ACC;
      end
      ACC: begin
        if (p == 4'd15) begin
          state_nx = DONE;
        end else begin
          state_nx = MUL;
`ifdef TC4_SKIP_ZERO_LIMB_EN
          if (skip_next) state_nx = ACC;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (clr) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      prod    <= '0;
      p       <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      acc     <= '0;
      prod    <= '0;
      p       <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            acc     <= '0;
            prod    <= '0;
            p       <= '0;
            bit_cnt <= '0;
          end
        end
        MUL: begin
          if (a_limb[bit_cnt]) prod <= prod ^ b_shift;
          bit_cnt <= bit_cnt + 1'b1;
        end
        ACC: begin
          acc     <= acc ^ prod_placed;
          prod    <= '0;
          bit_cnt <= '0;
          if (p != 4'd15) p <= p + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == MUL) || (state == ACC);
  assign out_valid = (state == DONE);
  assign c         = acc;

endmodule
